// File: rtl/decode_sched.sv
// rtl/decode_sched.sv - job-level scheduler for the LZS decode engine
//
// Runs one decode job at a time. For each job it clears the decoder,
// enables it, counts the bytes it produces against the expected length,
// throttles it, detects end/overrun/stall, and returns one status record.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   job_valid/ready   job descriptor handshake; job_id tag, job_olen length
//   dec_rst, dec_ce   decoder clear (active high) and enable
//   dec_out_valid     decoder produced one byte this cycle
//   dec_out_done      decoder reached END
//   fo_full           downstream output FIFO full
//   dec_fo_full       throttle to decoder: fo_full or length reached
//   sts_valid/ready   status handshake; sts_id, sts_len, sts_code
//                     (code 0 ok, 1 overrun, 2 timeout, 3 short)
module decode_sched #(
   parameter int CLR_CYC   = 2,
   parameter int DRAIN_CYC = 2,
   parameter int TMO_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [3:0]  job_id,
   input  logic [15:0] job_olen,
   output logic        dec_rst,
   output logic        dec_ce,
   input  logic        dec_out_valid,
   input  logic        dec_out_done,
   input  logic        fo_full,
   output logic        dec_fo_full,
   output logic        sts_valid,
   input  logic        sts_ready,
   output logic [3:0]  sts_id,
   output logic [15:0] sts_len,
   output logic [1:0]  sts_code
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_STS   = 3'd4
   } state_t;

   localparam logic [3:0] CLR_LAST   = 4'(CLR_CYC - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);
   // Value one below all-ones: incrementing from here makes the counter
   // reach all-ones, which is the timeout event.
   localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

   state_t            state;
   logic [3:0]        id_r;
   logic [15:0]       olen_r;
   logic [15:0]       byte_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [3:0]        ph_cnt;

   logic              at_limit;
   logic              overrun;
   logic              cnt_inc;
   logic [15:0]       byte_nxt;

   // byte_cnt can never exceed olen_r, so ">=" is the same as "==" here;
   // it also keeps the throttle high for the whole of an olen = 0 job.
   assign at_limit    = (byte_cnt >= olen_r);
   assign overrun     = dec_out_valid && at_limit;
   assign cnt_inc     = dec_out_valid && !at_limit;
   assign byte_nxt    = byte_cnt + {15'd0, cnt_inc};

   assign job_ready   = (state == S_IDLE);
   assign dec_fo_full = fo_full || at_limit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         id_r      <= '0;
         olen_r    <= '0;
         byte_cnt  <= '0;
         tmo_cnt   <= '0;
         ph_cnt    <= '0;
         dec_rst   <= 1'b0;
         dec_ce    <= 1'b0;
         sts_valid <= 1'b0;
         sts_id    <= '0;
         sts_len   <= '0;
         sts_code  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (job_valid) begin
                  id_r     <= job_id;
                  olen_r   <= job_olen;
                  byte_cnt <= '0;
                  tmo_cnt  <= '0;
                  sts_code <= 2'd0;
                  ph_cnt   <= '0;
                  dec_rst  <= 1'b1;
                  state    <= S_CLR;
               end
            end

            S_CLR: begin
               if (ph_cnt == CLR_LAST) begin
                  dec_rst <= 1'b0;
                  dec_ce  <= 1'b1;
                  ph_cnt  <= '0;
                  state   <= S_RUN;
               end else begin
                  ph_cnt <= ph_cnt + 4'd1;
               end
            end

            S_RUN: begin
               if (overrun) begin
                  sts_code  <= 2'd1;
                  dec_ce    <= 1'b0;
                  sts_valid <= 1'b1;
                  sts_id    <= id_r;
                  sts_len   <= byte_cnt;
                  state     <= S_STS;
               end else if (dec_out_done) begin
                  byte_cnt <= byte_nxt;
                  dec_ce   <= 1'b0;
                  ph_cnt   <= '0;
                  state    <= S_DRAIN;
               end else begin
                  byte_cnt <= byte_nxt;
                  // Any byte, or a full downstream FIFO, counts as progress.
                  if (dec_out_valid || fo_full) begin
                     tmo_cnt <= '0;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                     if (tmo_cnt == TMO_PRE) begin
                        sts_code  <= 2'd2;
                        dec_ce    <= 1'b0;
                        sts_valid <= 1'b1;
                        sts_id    <= id_r;
                        sts_len   <= byte_cnt;
                        state     <= S_STS;
                     end
                  end
               end
            end

            S_DRAIN: begin
               // Late history bytes are still counted and still overrun-checked.
               if (overrun) begin
                  sts_code  <= 2'd1;
                  sts_valid <= 1'b1;
                  sts_id    <= id_r;
                  sts_len   <= byte_cnt;
                  state     <= S_STS;
               end else begin
                  byte_cnt <= byte_nxt;
                  if (ph_cnt == DRAIN_LAST) begin
                     sts_code  <= (byte_nxt == olen_r) ? 2'd0 : 2'd3;
                     sts_valid <= 1'b1;
                     sts_id    <= id_r;
                     sts_len   <= byte_nxt;
                     state     <= S_STS;
                  end else begin
                     ph_cnt <= ph_cnt + 4'd1;
                  end
               end
            end

            S_STS: begin
               if (sts_ready) begin
                  sts_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decode_sched.sv
// tb/tb_decode_sched.sv - directed self-checking bench for decode_sched
module tb_decode_sched;

   logic        clk;
   logic        rst;
   logic        job_valid;
   logic        job_ready;
   logic [3:0]  job_id;
   logic [15:0] job_olen;
   logic        dec_rst;
   logic        dec_ce;
   logic        dec_out_valid;
   logic        dec_out_done;
   logic        fo_full;
   logic        dec_fo_full;
   logic        sts_valid;
   logic        sts_ready;
   logic [3:0]  sts_id;
   logic [15:0] sts_len;
   logic [1:0]  sts_code;

   int checks;
   int errors;

   decode_sched #(
      .CLR_CYC   (2),
      .DRAIN_CYC (2),
      .TMO_W     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_id        (job_id),
      .job_olen      (job_olen),
      .dec_rst       (dec_rst),
      .dec_ce        (dec_ce),
      .dec_out_valid (dec_out_valid),
      .dec_out_done  (dec_out_done),
      .fo_full       (fo_full),
      .dec_fo_full   (dec_fo_full),
      .sts_valid     (sts_valid),
      .sts_ready     (sts_ready),
      .sts_id        (sts_id),
      .sts_len       (sts_len),
      .sts_code      (sts_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept a job and run through CLR; returns at the start of the first RUN cycle.
   task automatic start_job(input logic [3:0] id, input logic [15:0] olen);
      job_valid = 1'b1;
      job_id    = id;
      job_olen  = olen;
      step();
      job_valid = 1'b0;
      step();
      step();
   endtask

   task automatic send_bytes(input int n);
      dec_out_valid = 1'b1;
      repeat (n) step();
      dec_out_valid = 1'b0;
   endtask

   task automatic wait_sts(input string tag, input int limit);
      int n;
      n = 0;
      while (!sts_valid && n < limit) begin
         step();
         n++;
      end
      chk(tag, 32'(sts_valid), 1);
   endtask

   task automatic ack();
      sts_ready = 1'b1;
      step();
      sts_ready = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b0;
      job_valid     = 1'b0;
      job_id        = '0;
      job_olen      = '0;
      dec_out_valid = 1'b0;
      dec_out_done  = 1'b0;
      fo_full       = 1'b0;
      sts_ready     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_job_ready", 32'(job_ready), 1);
      chk("rst_dec_rst", 32'(dec_rst), 0);
      chk("rst_dec_ce", 32'(dec_ce), 0);
      chk("rst_sts_valid", 32'(sts_valid), 0);
      chk("rst_sts_code", 32'(sts_code), 0);
      chk("rst_sts_len", 32'(sts_len), 0);
      rst = 1'b1;
      step();

      // 1. Nominal job: exact CLR/RUN/DRAIN timing
      job_valid = 1'b1;
      job_id    = 4'd5;
      job_olen  = 16'd10;
      step();
      job_valid = 1'b0;
      chk("t1_ready_low", 32'(job_ready), 0);
      chk("t1_clr1_rst", 32'(dec_rst), 1);
      chk("t1_clr1_ce", 32'(dec_ce), 0);
      step();
      chk("t1_clr2_rst", 32'(dec_rst), 1);
      step();
      chk("t1_run_rst", 32'(dec_rst), 0);
      chk("t1_run_ce", 32'(dec_ce), 1);
      chk("t1_throttle_lo", 32'(dec_fo_full), 0);
      send_bytes(10);
      chk("t1_throttle_hi", 32'(dec_fo_full), 1);
      dec_out_done = 1'b1;
      step();
      dec_out_done = 1'b0;
      chk("t1_drain_ce", 32'(dec_ce), 0);
      chk("t1_drain_nosts", 32'(sts_valid), 0);
      step();
      step();
      chk("t1_sts_valid", 32'(sts_valid), 1);
      chk("t1_sts_id", 32'(sts_id), 5);
      chk("t1_sts_len", 32'(sts_len), 10);
      chk("t1_sts_code", 32'(sts_code), 0);
      chk("t1_sts_ready_low", 32'(job_ready), 0);
      ack();
      chk("t1_sts_drop", 32'(sts_valid), 0);
      chk("t1_ready_back", 32'(job_ready), 1);

      // 2. Short job with a late byte inside DRAIN
      start_job(4'd2, 16'd20);
      send_bytes(12);
      dec_out_done = 1'b1;
      step();
      dec_out_done = 1'b0;
      send_bytes(1);
      step();
      chk("t2_sts_valid", 32'(sts_valid), 1);
      chk("t2_sts_id", 32'(sts_id), 2);
      chk("t2_sts_len", 32'(sts_len), 13);
      chk("t2_sts_code", 32'(sts_code), 3);
      ack();

      // 3. Overrun
      start_job(4'd3, 16'd4);
      send_bytes(3);
      chk("t3_throttle_3", 32'(dec_fo_full), 0);
      send_bytes(1);
      chk("t3_throttle_4", 32'(dec_fo_full), 1);
      chk("t3_no_sts_yet", 32'(sts_valid), 0);
      send_bytes(1);
      chk("t3_sts_valid", 32'(sts_valid), 1);
      chk("t3_ce_low", 32'(dec_ce), 0);
      chk("t3_sts_len", 32'(sts_len), 4);
      chk("t3_sts_code", 32'(sts_code), 1);
      ack();

      // 4a. Timeout after 15 idle RUN cycles (TMO_W = 4)
      start_job(4'd4, 16'd8);
      repeat (14) step();
      chk("t4_no_tmo_14", 32'(sts_valid), 0);
      step();
      chk("t4_tmo_valid", 32'(sts_valid), 1);
      chk("t4_tmo_code", 32'(sts_code), 2);
      chk("t4_tmo_len", 32'(sts_len), 0);
      chk("t4_tmo_id", 32'(sts_id), 4);
      ack();

      // 4b. fo_full held: no timeout
      start_job(4'd6, 16'd3);
      fo_full = 1'b1;
      repeat (40) step();
      chk("t4_full_no_tmo", 32'(sts_valid), 0);
      chk("t4_full_ce", 32'(dec_ce), 1);
      fo_full = 1'b0;
      send_bytes(3);
      dec_out_done = 1'b1;
      step();
      dec_out_done = 1'b0;
      wait_sts("t4_full_sts_timeout", 10);
      chk("t4_full_code", 32'(sts_code), 0);
      chk("t4_full_len", 32'(sts_len), 3);

      // 5. Status backpressure with a pending job (olen = 0)
      job_valid = 1'b1;
      job_id    = 4'd7;
      job_olen  = 16'd0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t5_hold_valid", 32'(sts_valid), 1);
         chk("t5_hold_id", 32'(sts_id), 6);
         chk("t5_hold_len", 32'(sts_len), 3);
         chk("t5_hold_code", 32'(sts_code), 0);
         chk("t5_hold_ready", 32'(job_ready), 0);
      end
      sts_ready = 1'b1;
      step();
      sts_ready = 1'b0;
      chk("t5_hs_drop", 32'(sts_valid), 0);
      chk("t5_hs_ready", 32'(job_ready), 1);
      chk("t5_hs_no_clr", 32'(dec_rst), 0);
      step();
      job_valid = 1'b0;
      chk("t5_accept_rst", 32'(dec_rst), 1);
      chk("t5_accept_ready", 32'(job_ready), 0);
      step();
      step();
      chk("t5_zero_throttle", 32'(dec_fo_full), 1);
      dec_out_done = 1'b1;
      step();
      dec_out_done = 1'b0;
      wait_sts("t5_zero_sts_timeout", 10);
      chk("t5_zero_code", 32'(sts_code), 0);
      chk("t5_zero_len", 32'(sts_len), 0);
      chk("t5_zero_id", 32'(sts_id), 7);
      ack();

      // 6. Asynchronous reset mid-RUN
      start_job(4'd9, 16'd5);
      send_bytes(2);
      chk("t6_pre_ce", 32'(dec_ce), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_ce", 32'(dec_ce), 0);
      chk("t6_async_sts", 32'(sts_valid), 0);
      chk("t6_async_ready", 32'(job_ready), 1);
      step();
      rst = 1'b1;
      repeat (5) step();
      chk("t6_no_stale_sts", 32'(sts_valid), 0);
      chk("t6_no_restart", 32'(dec_rst), 0);
      chk("t6_idle_ready", 32'(job_ready), 1);

      // olen = 0: any byte is an overrun
      start_job(4'd12, 16'd0);
      send_bytes(1);
      chk("t7_zero_ovr_valid", 32'(sts_valid), 1);
      chk("t7_zero_ovr_code", 32'(sts_code), 1);
      chk("t7_zero_ovr_len", 32'(sts_len), 0);
      ack();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_sched.md
Name: decode_sched

Overview:
Job-level controller for the LZS decode engine (decode_ctl).
- Accepts one decode job at a time (id plus expected output length) and clears the decoder between jobs.
- Enables the decoder, counts produced bytes, throttles it through the output-full input, detects end/overrun/stall, and returns one status record per job.
- Sits between the host descriptor queue and decode_ctl.

Parameters:
- CLR_CYC, 2: cycles dec_rst is held high before a job starts (1..15).
- DRAIN_CYC, 2: cycles after dec_out_done during which late history bytes are still counted (1..15).
- TMO_W, 16: width of the stall timeout counter; timeout fires when the counter reaches all-ones.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  scheduler can accept a job.
- job_id  in  4  job tag, returned in status.
- job_olen  in  16  expected output byte count.
- dec_rst  out  1  active-high clear to the decoder.
- dec_ce  out  1  decoder enable (decode_ctl ce).
- dec_out_valid  in  1  decoder produced one byte this cycle.
- dec_out_done  in  1  decoder reached END.
- fo_full  in  1  downstream output FIFO full.
- dec_fo_full  out  1  throttle to the decoder: fo_full OR (byte_cnt >= olen_r).
- sts_valid  out  1  status record valid.
- sts_ready  in  1  status consumer ready.
- sts_id  out  4  captured job_id.
- sts_len  out  16  bytes actually counted.
- sts_code  out  2  0 ok, 1 overrun, 2 timeout, 3 short.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - job_ready = 1; dec_rst, dec_ce, sts_valid = 0.
  - sts_id, sts_len, sts_code = 0; byte_cnt, tmo_cnt, phase counter = 0.
- Reset mid-job aborts the job silently; no status record is produced.
- All outputs are registered except:
  - job_ready = (state == IDLE);
  - dec_fo_full, which is combinational from fo_full and registered byte_cnt/olen_r.
- IDLE:
  - job accepted when job_valid && job_ready.
  - On accept: capture job_id into id_r and job_olen into olen_r; clear byte_cnt, tmo_cnt and sts_code; next state CLR.
- CLR:
  - dec_rst = 1 for exactly CLR_CYC cycles; dec_ce = 0.
  - Then RUN; dec_ce rises on the first RUN cycle.
- RUN:
  - dec_ce = 1.
  - Each dec_out_valid with byte_cnt < olen_r increments byte_cnt (16-bit, no wrap possible).
  - dec_out_valid with byte_cnt == olen_r:
    - byte is not counted; sts_code = 1; next state STS. Overrun takes priority over done in the same cycle.
  - dec_out_done (no overrun): next state DRAIN. A byte valid in the same cycle is counted.
  - Timeout counter:
    - cleared on any dec_out_valid or while fo_full = 1; otherwise increments.
    - at all-ones: sts_code = 2, next state STS.
    - lowest priority: overrun, then done, then timeout.
- DRAIN:
  - dec_ce = 0 for DRAIN_CYC cycles; bytes are still counted and overrun is still checked (same rule, goes to STS).
  - At the end: sts_code = 0 if byte_cnt == olen_r, else 3; next state STS.
- STS:
  - sts_valid = 1; sts_id = id_r, sts_len = byte_cnt, sts_code held stable until sts_ready.
  - dec_ce = 0; dec_out_valid is ignored.
  - On sts_valid && sts_ready: sts_valid drops next cycle; state IDLE.
  - job_ready is 0 throughout STS, so there is no job/status overlap.
- olen = 0: dec_fo_full is held high for the whole job; any byte is an overrun; done with no bytes gives code 0, len 0.
- Latency from job accept to the first dec_ce high: CLR_CYC + 1 cycles.

Test Plan:
1. Nominal job:
   - Stimulus: id=5, olen=10; 10 dec_out_valid pulses, then dec_out_done.
   - Response: dec_rst high 2 cycles, dec_ce high from cycle 3; status id=5, len=10, code=0; job_ready returns after sts_ready.
2. Short job:
   - Stimulus: olen=20; 12 bytes, then done; 1 late byte inside DRAIN.
   - Response: len=13, code=3.
3. Overrun:
   - Stimulus: olen=4; 5 valid pulses.
   - Response: dec_fo_full rises after the 4th byte; 5th byte gives code=1, len=4, dec_ce low next cycle.
4. Timeout:
   - Stimulus: TMO_W=4, fo_full=0, no decoder activity.
   - Response: code=2 after 15 idle RUN cycles.
   - Repeat with fo_full=1: no timeout occurs.
5. Status backpressure:
   - Stimulus: sts_ready held low 8 cycles with a job_valid pending.
   - Response: sts fields stable, job_ready=0, next job accepted only in the cycle after the handshake.
6. Asynchronous reset:
   - Stimulus: rst low mid-RUN, asynchronous to clk.
   - Response: dec_ce and sts_valid drop immediately, job_ready=1; no stale status after release.
